// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: next-PC select codes, fetch FSM states and NOP encoding shared with the decoder.
package fetch_unit_pkg;

    localparam logic [1:0] PC_MUX_PLUS4  = 2'd0;
    localparam logic [1:0] PC_MUX_TARGET = 2'd1;
    localparam logic [1:0] PC_MUX_ALU    = 2'd2;
    localparam logic [1:0] PC_MUX_BREAK  = 2'd3;

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        FETCH_ST_START,
        FETCH_ST_FETCH,
        FETCH_ST_VALID,
        FETCH_ST_HALT
    } fetch_state_e;

endpackage

// File: rtl/fetch_unit_pc_next_sel.sv
// pc_next_sel: combinational next-PC mux with break and misalignment detection.
module pc_next_sel
    import fetch_unit_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] pc,
    input  logic [1:0]      pc_src,
    input  logic [XLEN-1:0] imm_ext,
    input  logic [XLEN-1:0] alu_result,
    output logic [XLEN-1:0] next_pc,
    output logic            is_break,
    output logic            misaligned
);

    assign is_break   = pc_src == PC_MUX_BREAK;
    assign next_pc    = pc_src == PC_MUX_TARGET ? pc + imm_ext :
                        pc_src == PC_MUX_ALU    ? alu_result & ~XLEN'(1) :
                        is_break                ? pc : pc + XLEN'(4);
    assign misaligned = !is_break && |next_pc[1:0];

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC owner and single-outstanding instruction fetch with halt/resume and misalign trap.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [31:0]     imem_rdata,
    output logic [31:0]     instr,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_plus4,
    input  logic [1:0]      pc_src,
    input  logic [XLEN-1:0] imm_ext,
    input  logic [XLEN-1:0] alu_result,
    input  logic            dbg_resume,
    output logic            halted,
    output logic            misalign
);

    fetch_state_e    state;
    logic [XLEN-1:0] next_pc;
    logic            is_break;
    logic            misaligned;

    assign imem_addr = pc;
    assign pc_plus4  = pc + XLEN'(4);

    pc_next_sel #(.XLEN(XLEN)) u_pc_next_sel (
        .pc         (pc),
        .pc_src     (pc_src),
        .imm_ext    (imm_ext),
        .alu_result (alu_result),
        .next_pc    (next_pc),
        .is_break   (is_break),
        .misaligned (misaligned)
    );

    // Outputs are registered alongside the state so they change only on state transitions.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= FETCH_ST_START;
            pc          <= RESET_PC;
            instr       <= NOP;
            instr_valid <= 1'b0;
            imem_req    <= 1'b0;
            halted      <= 1'b0;
            misalign    <= 1'b0;
        end else begin
            case (state)
                FETCH_ST_START: begin
                    state    <= FETCH_ST_FETCH;
                    imem_req <= 1'b1;
                end
                FETCH_ST_FETCH: if (imem_ack) begin
                    instr       <= imem_rdata;
                    imem_req    <= 1'b0;
                    instr_valid <= 1'b1;
                    state       <= FETCH_ST_VALID;
                end
                FETCH_ST_VALID: if (instr_ready) begin
                    instr_valid <= 1'b0;
                    if (is_break || misaligned) begin
                        halted   <= 1'b1;
                        misalign <= misaligned;
                        state    <= FETCH_ST_HALT;
                    end else begin
                        pc       <= next_pc;
                        imem_req <= 1'b1;
                        state    <= FETCH_ST_FETCH;
                    end
                end
                FETCH_ST_HALT: if (dbg_resume) begin
                    pc       <= pc_plus4;
                    misalign <= 1'b0;
                    halted   <= 1'b0;
                    imem_req <= 1'b1;
                    state    <= FETCH_ST_FETCH;
                end
                default: state <= FETCH_ST_START;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed scenarios plus randomized fetch/consume traffic against a next-PC reference model.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [1:0]  pc_src;
    logic [31:0] imm_ext;
    logic [31:0] alu_result;
    logic        dbg_resume;
    logic        halted;
    logic        misalign;

    int          checks = 0;
    int          passed = 0;
    logic [31:0] exp_pc;
    bit          ok;
    bit          held;
    logic [31:0] a;
    int          rc;
    logic [31:0] rd;

    fetch_unit dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .instr       (instr),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .pc          (pc),
        .pc_plus4    (pc_plus4),
        .pc_src      (pc_src),
        .imm_ext     (imm_ext),
        .alu_result  (alu_result),
        .dbg_resume  (dbg_resume),
        .halted      (halted),
        .misalign    (misalign)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, %0d/%0d so far", passed, checks);
        $fatal(1, "watchdog");
    end

    // Reference next-PC rule using 64-bit arithmetic reduced modulo 2^32.
    function automatic void ref_next(input logic [31:0] cur, input logic [1:0] src,
                                     input logic [31:0] imm, input logic [31:0] alu,
                                     output logic [31:0] nxt, output bit stop, output bit mis);
        longint unsigned t;
        case (src)
            2'd0:    t = ({32'd0, cur} + 64'd4) % 64'h1_0000_0000;
            2'd1:    t = ({32'd0, cur} + {32'd0, imm}) % 64'h1_0000_0000;
            2'd2:    t = {32'd0, alu} - ({32'd0, alu} % 64'd2);
            default: t = {32'd0, cur};
        endcase
        nxt  = t[31:0];
        mis  = (src != 2'd3) && (t % 64'd4 != 64'd0);
        stop = (src == 2'd3) || mis;
    endfunction

    function automatic logic [31:0] plus4(input logic [31:0] v);
        longint unsigned t;
        t = ({32'd0, v} + 64'd4) % 64'h1_0000_0000;
        return t[31:0];
    endfunction

    task automatic do_fetch(input logic [31:0] data, input int waits, output bit f_ok,
                            output logic [31:0] f_addr, output int f_req, output bit f_held);
        f_ok = 0; f_held = 1; f_req = 0; f_addr = 'x;
        for (int i = 0; i < 20 && !f_ok; i++) begin
            if (imem_req === 1'b1) f_ok = 1;
            else @(negedge clk);
        end
        if (!f_ok) return;
        f_addr = imem_addr;
        for (int i = 0; i <= waits; i++) begin
            if (imem_req === 1'b1) f_req++;
            imem_ack   = (i == waits);
            imem_rdata = (i == waits) ? data : $urandom;
            @(posedge clk);
            @(negedge clk);
            imem_ack = 1'b0;
            if (i < waits && (imem_req !== 1'b1 || imem_addr !== f_addr)) f_held = 0;
        end
    endtask

    task automatic consume(input logic [1:0] src, input logic [31:0] imm, input logic [31:0] alu);
        pc_src = src; imm_ext = imm; alu_result = alu; instr_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        instr_ready = 1'b0; pc_src = 2'($urandom); imm_ext = $urandom; alu_result = $urandom;
    endtask

    task automatic resume();
        dbg_resume = 1'b1;
        @(posedge clk);
        @(negedge clk);
        dbg_resume = 1'b0;
    endtask

    task automatic goto(input logic [31:0] target);
        bit g_ok, g_held;
        logic [31:0] g_a;
        int g_rc;
        consume(2'd1, target - exp_pc, 32'd0);
        exp_pc = target;
        do_fetch($urandom, $urandom_range(0, 2), g_ok, g_a, g_rc, g_held);
    endtask

    task automatic test_reset();
        logic [31:0] prev;
        rst_n = 1'b0; imem_ack = 1'b0; imem_rdata = '0; instr_ready = 1'b0; pc_src = '0;
        imm_ext = '0; alu_result = '0; dbg_resume = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (pc !== 32'd0 || imem_addr !== 32'd0 || pc_plus4 !== 32'd4) $display("FAIL reset_pc: pc %h addr %h plus4 %h, want 0/0/4", pc, imem_addr, pc_plus4); else passed++;
        checks++; if (instr !== 32'h0000_0013) $display("FAIL reset_instr: got %h want 00000013", instr); else passed++;
        checks++; if ({instr_valid, imem_req, halted, misalign} !== 4'b0) $display("FAIL reset_flags: valid/req/halt/mis = %b want 0000", {instr_valid, imem_req, halted, misalign}); else passed++;
        imem_ack = 1'b1; instr_ready = 1'b1;
        rst_n = 1'b1;
        #1;
        checks++; if (imem_req !== 1'b0) $display("FAIL start_req: got %b want 0 before first edge", imem_req); else passed++;
        prev = '0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (k % 2 == 1) begin
                checks++; if (imem_req !== 1'b1 || instr_valid !== 1'b0 || imem_addr !== 32'(4 * (k / 2))) $display("FAIL seq_fetch%0d: req %b valid %b addr %h, want 1 0 %h", k, imem_req, instr_valid, imem_addr, 4 * (k / 2)); else passed++;
                prev = imem_addr;
                imem_rdata = imem_addr ^ 32'hC0DE_0000;
            end else begin
                checks++; if (instr_valid !== 1'b1 || imem_req !== 1'b0 || pc !== prev || instr !== (prev ^ 32'hC0DE_0000) || pc_plus4 !== prev + 32'd4) $display("FAIL seq_valid%0d: valid %b req %b pc %h instr %h, want 1 0 %h %h", k, instr_valid, imem_req, pc, instr, prev, prev ^ 32'hC0DE_0000); else passed++;
            end
        end
        imem_ack = 1'b0; instr_ready = 1'b0;
        exp_pc = 32'hC;
    endtask

    task automatic test_wait_states();
        consume(2'd0, 32'd0, 32'd0);
        exp_pc = 32'h10;
        rd = $urandom;
        do_fetch(rd, 3, ok, a, rc, held);
        checks++; if (!ok || a !== 32'h10 || rc != 4 || !held) $display("FAIL wait_hold: ok %0d addr %h req_cycles %0d held %0d, want 1 10 4 1", ok, a, rc, held); else passed++;
        checks++; if (instr !== rd || instr_valid !== 1'b1 || imem_req !== 1'b0) $display("FAIL wait_instr: instr %h valid %b req %b, want %h 1 0", instr, instr_valid, imem_req, rd); else passed++;
    endtask

    task automatic test_branch();
        for (int i = 0; i < 4; i++) begin
            consume(2'd0, 32'd0, 32'd0);
            exp_pc += 32'd4;
            do_fetch($urandom, $urandom_range(0, 2), ok, a, rc, held);
        end
        checks++; if (pc !== 32'h20) $display("FAIL branch_start: pc %h want 00000020", pc); else passed++;
        consume(2'd1, 32'hFFFF_FFF8, 32'd0);
        do_fetch($urandom, 0, ok, a, rc, held);
        checks++; if (!ok || a !== 32'h18) $display("FAIL branch_target: ok %0d addr %h want 00000018", ok, a); else passed++;
        consume(2'd2, 32'd0, 32'h101);
        do_fetch($urandom, 1, ok, a, rc, held);
        checks++; if (!ok || a !== 32'h100 || pc_plus4 !== 32'h104) $display("FAIL jalr_target: ok %0d addr %h plus4 %h want 00000100 00000104", ok, a, pc_plus4); else passed++;
        exp_pc = 32'h100;
    endtask

    task automatic test_misalign();
        goto(32'h40);
        consume(2'd1, 32'h6, 32'd0);
        checks++; if (halted !== 1'b1 || misalign !== 1'b1 || pc !== 32'h40 || imem_req !== 1'b0 || instr_valid !== 1'b0) $display("FAIL misalign_halt: halt %b mis %b pc %h req %b valid %b, want 1 1 40 0 0", halted, misalign, pc, imem_req, instr_valid); else passed++;
        resume();
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h44 || misalign !== 1'b0 || halted !== 1'b0) $display("FAIL misalign_resume: req %b addr %h mis %b halt %b, want 1 44 0 0", imem_req, imem_addr, misalign, halted); else passed++;
        do_fetch($urandom, 0, ok, a, rc, held);
        exp_pc = 32'h44;
    endtask

    task automatic test_ebreak();
        int bad = 0;
        goto(32'h50);
        consume(2'd3, $urandom, $urandom);
        checks++; if (halted !== 1'b1 || misalign !== 1'b0 || pc !== 32'h50) $display("FAIL ebreak_halt: halt %b mis %b pc %h, want 1 0 50", halted, misalign, pc); else passed++;
        instr_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            imem_ack = 1'($urandom); pc_src = 2'($urandom);
            @(negedge clk);
            if (pc !== 32'h50 || halted !== 1'b1 || imem_req !== 1'b0 || instr_valid !== 1'b0) bad++;
        end
        instr_ready = 1'b0; imem_ack = 1'b0;
        checks++; if (bad != 0) $display("FAIL ebreak_hold: %0d bad cycles of 20, want 0", bad); else passed++;
        resume();
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h54 || halted !== 1'b0) $display("FAIL ebreak_resume: req %b addr %h halt %b, want 1 54 0", imem_req, imem_addr, halted); else passed++;
        do_fetch($urandom, 0, ok, a, rc, held);
        exp_pc = 32'h54;
    endtask

    task automatic test_wrap();
        consume(2'd2, 32'd0, 32'hFFFF_FFFD);
        do_fetch($urandom, 0, ok, a, rc, held);
        checks++; if (pc !== 32'hFFFF_FFFC || pc_plus4 !== 32'd0) $display("FAIL wrap_top: pc %h plus4 %h, want fffffffc 0", pc, pc_plus4); else passed++;
        consume(2'd0, 32'd0, 32'd0);
        checks++; if (halted !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'd0) $display("FAIL wrap_zero: halt %b req %b addr %h, want 0 1 0", halted, imem_req, imem_addr); else passed++;
        do_fetch($urandom, 0, ok, a, rc, held);
        exp_pc = 32'd0;
    endtask

    task automatic test_random();
        logic [1:0]  src;
        logic [31:0] imm, alu, nxt;
        bit          stop, mis;
        int          r;
        for (int n = 0; n < 150; n++) begin
            r   = $urandom_range(0, 9);
            src = r < 4 ? 2'd0 : r < 7 ? 2'd1 : r < 9 ? 2'd2 : 2'd3;
            imm = $urandom_range(0, 3) == 0 ? $urandom : ($urandom & 32'hFFFF_FFFC);
            alu = $urandom;
            ref_next(exp_pc, src, imm, alu, nxt, stop, mis);
            consume(src, imm, alu);
            if (stop) begin
                checks++; if (halted !== 1'b1 || misalign !== mis || pc !== exp_pc || imem_req !== 1'b0) $display("FAIL rand_halt%0d: halt %b mis %b pc %h req %b, want 1 %0d %h 0", n, halted, misalign, pc, imem_req, mis, exp_pc); else passed++;
                repeat ($urandom_range(0, 3)) begin
                    imem_ack = 1'($urandom); instr_ready = 1'($urandom);
                    @(negedge clk);
                end
                imem_ack = 1'b0; instr_ready = 1'b0;
                resume();
                exp_pc = plus4(exp_pc);
            end else begin
                exp_pc = nxt;
            end
            checks++; if (imem_req !== 1'b1 || imem_addr !== exp_pc || halted !== 1'b0 || misalign !== 1'b0) $display("FAIL rand_req%0d: req %b addr %h halt %b mis %b, want 1 %h 0 0", n, imem_req, imem_addr, halted, misalign, exp_pc); else passed++;
            rd = $urandom;
            do_fetch(rd, $urandom_range(0, 3), ok, a, rc, held);
            checks++; if (!ok || !held || instr !== rd || instr_valid !== 1'b1 || pc !== exp_pc || pc_plus4 !== plus4(exp_pc)) $display("FAIL rand_fetch%0d: ok %0d held %0d instr %h valid %b pc %h, want %h 1 %h", n, ok, held, instr, instr_valid, pc, rd, exp_pc); else passed++;
        end
    endtask

    task automatic test_reset_mid();
        goto(32'h7C);
        consume(2'd0, 32'd0, 32'd0);
        repeat (2) @(negedge clk);
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h80) $display("FAIL mid_wait: req %b addr %h, want 1 80", imem_req, imem_addr); else passed++;
        #2 rst_n = 1'b0;
        #1;
        checks++; if (imem_req !== 1'b0 || pc !== 32'd0 || instr_valid !== 1'b0 || instr !== 32'h0000_0013) $display("FAIL mid_reset: req %b pc %h valid %b instr %h, want 0 0 0 00000013", imem_req, pc, instr_valid, instr); else passed++;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'd0) $display("FAIL mid_restart: req %b addr %h, want 1 0", imem_req, imem_addr); else passed++;
        rd = $urandom;
        do_fetch(rd, 1, ok, a, rc, held);
        checks++; if (!ok || instr !== rd || pc !== 32'd0) $display("FAIL mid_fetch: ok %0d instr %h pc %h, want 1 %h 0", ok, instr, pc, rd); else passed++;
        exp_pc = 32'd0;
    endtask

    initial begin
        test_reset();
        test_wait_states();
        test_branch();
        test_misalign();
        test_ebreak();
        test_wrap();
        test_random();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
